uart_rx_ctrl: RTL and testbench

- Receive-side frame controller for the UART.
- Detects start bits on the line and generates oversampled mid-bit sample ticks.
- Sequences the serial-to-parallel deserializer through the data bits.
- Checks parity and stop bits, then signals frame completion, data validity and errors to the register/interface layer.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_if.sv | 29 ++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 102 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the UART receive controller.
//   state_t / IDLE..STOP : FSM state encoding (legacy 3-bit constants)
//   PRESCALE_*           : legal oversampling ratios and the fallback ratio
//   PAR_EVEN / PAR_ODD   : PAR_TYP encodings
//   norm_prescale()      : maps any requested ratio onto a legal one
package uart_rx_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
   localparam int unsigned PRESCALE_8   = 8;
   localparam int unsigned PRESCALE_16  = 16;
   localparam int unsigned PRESCALE_32  = 32;
   localparam int unsigned PRESCALE_DEF = PRESCALE_16;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   function automatic int unsigned norm_prescale(input int unsigned p);
      return (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_DEF;
   endfunction
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: deserializer handshake and frame status bundle of the receive controller.
//   DESER_DATA    : parallel word from the deserializer (used for parity)
//   DESER_EN      : deserializer enable, low clears its bit counter
//   DESER_TICK_EN : deserializer may shift on SAMPLE_TICK
//   SAMPLE_TICK / SAMPLED_BIT : mid-bit strobe and the sampled line value
//   DATA_VALID / FRAME_DONE / PAR_ERR / STP_ERR / STRT_GLITCH : frame status
//   master : controller side, slave : deserializer/register side
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] DESER_DATA;
   logic DESER_EN;
   logic DESER_TICK_EN;
   logic SAMPLE_TICK;
   logic SAMPLED_BIT;
   logic DATA_VALID;
   logic FRAME_DONE;
   logic PAR_ERR;
   logic STP_ERR;
   logic STRT_GLITCH;
   modport master (
      input  DESER_DATA,
      output DESER_EN, DESER_TICK_EN, SAMPLE_TICK, SAMPLED_BIT,
             DATA_VALID, FRAME_DONE, PAR_ERR, STP_ERR, STRT_GLITCH
   );
   modport slave (
      output DESER_DATA,
      input  DESER_EN, DESER_TICK_EN, SAMPLE_TICK, SAMPLED_BIT,
             DATA_VALID, FRAME_DONE, PAR_ERR, STP_ERR, STRT_GLITCH
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and mid-bit line sampler.
//   CLK, RST    : clock, asynchronous active-low reset
//   en          : counting enable from the FSM; low holds ec at 0
//   rx_in       : synchronized serial line
//   p           : latched oversampling ratio P
//   ec          : edge counter 0..P-1
//   sample_tick : strobe at ec == P/2+1
//   sampled_bit : captured (or 2-of-3 voted) line value
// Macro UART_RX_MAJORITY_SAMPLE_EN: capture at P/2-2, P/2-1, P/2 and vote;
// otherwise a single capture at P/2.
module uart_rx_sampler #(parameter int PRESCALE_W = 6) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  en,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] p,
   output logic [PRESCALE_W-1:0] ec,
   output logic                  sample_tick,
   output logic                  sampled_bit
);
   logic [PRESCALE_W-1:0] half;
   assign half = p >> 1;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) ec <= '0;
      else ec <= (!en || ec == p - PRESCALE_W'(1)) ? '0 : ec + PRESCALE_W'(1);
   assign sample_tick = en && ec == half + PRESCALE_W'(1);
`ifdef UART_RX_MAJORITY_SAMPLE_EN
   logic [2:0] cap;
   // Three consecutive captures ending at P/2 shift through cap.
   always_ff @(posedge CLK or negedge RST)
      if (!RST) cap <= '0;
      else if (en && ec >= half - PRESCALE_W'(2) && ec <= half) cap <= {cap[1:0], rx_in};
   assign sampled_bit = (cap[0] & cap[1]) | (cap[1] & cap[2]) | (cap[0] & cap[2]);
`else
   logic cap;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) cap <= 1'b0;
      else if (en && ec == half) cap <= rx_in;
   assign sampled_bit = cap;
`endif
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start detect, bit sequencing,
// parity/stop checking and frame status).
//   CLK, RST  : clock, asynchronous active-low reset
//   RX_IN     : synchronized serial line, idle high
//   PRESCALE  : oversampling ratio (8/16/32, anything else runs as 16)
//   PAR_EN    : parity bit present
//   PAR_TYP   : 0 even, 1 odd
//   bus       : uart_rx_ctrl_if.master (deserializer control and frame status)
// Macro UART_RX_MAJORITY_SAMPLE_EN selects 2-of-3 voting in uart_rx_sampler.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   uart_rx_ctrl_if.master        bus
);
   localparam int BC_W = $clog2(DATA_WIDTH);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);
   state_t state;
   logic [PRESCALE_W-1:0] p_q, ec;
   logic [BC_W-1:0] bc;
   logic par_en_q, par_typ_q, tick, sbit, last;
   logic frame_done, data_valid, par_err, stp_err, strt_glitch;
   assign last = ec == p_q - PRESCALE_W'(1);
   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .CLK        (CLK),
      .RST        (RST),
      .en         (state != IDLE),
      .rx_in      (RX_IN),
      .p          (p_q),
      .ec         (ec),
      .sample_tick(tick),
      .sampled_bit(sbit)
   );
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state       <= IDLE;
         p_q         <= '0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         bc          <= '0;
         frame_done  <= 1'b0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         data_valid  <= 1'b0;
         strt_glitch <= 1'b0;
         case (state)
            IDLE:
               if (!RX_IN) begin
                  state     <= START;
                  p_q       <= PRESCALE_W'(norm_prescale(32'(PRESCALE)));
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  par_err   <= 1'b0;
                  stp_err   <= 1'b0;
               end
            START:
               if (tick && sbit) begin
                  strt_glitch <= 1'b1;
                  state       <= IDLE;
               end else if (last) state <= DATA;
            DATA:
               if (last) begin
                  bc <= (bc == BC_LAST) ? '0 : bc + BC_W'(1);
                  if (bc == BC_LAST) state <= par_en_q ? PARITY : STOP;
               end
            PARITY: begin
               if (tick && sbit != (^bus.DESER_DATA ^ par_typ_q)) par_err <= 1'b1;
               if (last) state <= STOP;
            end
            // Frame closes at mid stop bit so the next start edge is caught.
            STOP:
               if (tick) begin
                  stp_err    <= !sbit;
                  frame_done <= 1'b1;
                  data_valid <= !par_err && sbit;
                  state      <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   assign bus.DESER_EN      = state == DATA || state == PARITY || state == STOP;
   assign bus.DESER_TICK_EN = state == DATA;
   assign bus.SAMPLE_TICK   = tick;
   assign bus.SAMPLED_BIT   = sbit;
   assign bus.DATA_VALID    = data_valid;
   assign bus.FRAME_DONE    = frame_done;
   assign bus.PAR_ERR       = par_err;
   assign bus.STP_ERR       = stp_err;
   assign bus.STRT_GLITCH   = strt_glitch;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a deserializer stand-in and a frame-level reference model.
module tb_uart_rx_ctrl;
   typedef struct packed {logic [7:0] d; logic pe; logic se; logic dv;} rec_t;
   logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
   logic [5:0] PRESCALE = 6'd16;
   logic [7:0] deser;
   int vectors = 0, miscompares = 0;
   int fd_n = 0, dv_n = 0, gl_n = 0, en_n = 0, dt_n = 0, tk_n = 0;
   rec_t got[$];
   uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();
   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .bus(bus.master)
   );
   always #5 CLK = ~CLK;
   // Deserializer stand-in: shifts LSB-first on data ticks, cleared while disabled.
   always @(posedge CLK or negedge RST)
      if (!RST) deser <= '0;
      else if (!bus.DESER_EN) deser <= '0;
      else if (bus.SAMPLE_TICK && bus.DESER_TICK_EN) deser <= {bus.SAMPLED_BIT, deser[7:1]};
   assign bus.DESER_DATA = deser;
   always @(negedge CLK) begin
      if (bus.FRAME_DONE) begin
         fd_n++;
         got.push_back({bus.DESER_DATA, bus.PAR_ERR, bus.STP_ERR, bus.DATA_VALID});
      end
      if (bus.DATA_VALID) dv_n++;
      if (bus.STRT_GLITCH) gl_n++;
      if (bus.DESER_EN) en_n++;
      if (bus.SAMPLE_TICK && bus.DESER_TICK_EN) dt_n++;
      if (bus.SAMPLE_TICK) tk_n++;
   end
   function automatic logic [8:0] outs();
      return {bus.DESER_EN, bus.DESER_TICK_EN, bus.SAMPLE_TICK, bus.SAMPLED_BIT, bus.DATA_VALID,
              bus.FRAME_DONE, bus.PAR_ERR, bus.STP_ERR, bus.STRT_GLITCH};
   endfunction
   function automatic int norm_p(input int p);
      return (p == 8 || p == 16 || p == 32) ? p : 16;
   endfunction
   // Frame outcome from the protocol rules: data as sent, parity compared against XOR(data)^type.
   function automatic rec_t model(input logic [7:0] d, input bit pen, ptyp, pbit, stop);
      rec_t r;
      r.d  = d;
      r.pe = pen && (pbit != (^d ^ ptyp));
      r.se = !stop;
      r.dv = !r.pe && !r.se;
      return r;
   endfunction
   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask
   task automatic drive_bit(input logic v, input int p, input bit g);
      RX_IN = v;
      if (g) begin
         wait_cyc(p / 2 + 1);
         RX_IN = !v;
         wait_cyc(1);
         RX_IN = v;
         wait_cyc(p - p / 2 - 2);
      end else wait_cyc(p);
   endtask
   task automatic send_rest(input logic [7:0] d, input int praw, input bit pen, ptyp, pbit, stop, input int gbit);
      int p = norm_p(praw);
      PRESCALE = 6'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p, i == gbit);
      PRESCALE = praw[5:0];
      PAR_EN = pen;
      PAR_TYP = ptyp;
      if (pen) drive_bit(pbit, p, 1'b0);
      drive_bit(stop, p, 1'b0);
   endtask
   task automatic send_frame(input logic [7:0] d, input int praw, input bit pen, ptyp, pbit, stop, input int gbit);
      PRESCALE = praw[5:0];
      PAR_EN = pen;
      PAR_TYP = ptyp;
      drive_bit(1'b0, norm_p(praw), 1'b0);
      send_rest(d, praw, pen, ptyp, pbit, stop, gbit);
   endtask
   task automatic test_reset();
      RST = 1'b0;
      RX_IN = 1'b1;
      wait_cyc(3);
      vectors++; if (outs() !== 9'h0) begin miscompares++; $display("FAIL reset_outs: got %b want %b", outs(), 9'h0); end
      RST = 1'b1;
      wait_cyc(4);
      vectors++; if (outs() !== 9'h0) begin miscompares++; $display("FAIL idle_outs: got %b want %b", outs(), 9'h0); end
   endtask
   task automatic test_basic();
      int b = got.size(), bdt = dt_n, bdv = dv_n, bfd = fd_n;
      rec_t e = model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      RX_IN = 1'b1;
      wait_cyc(8);
      vectors++; if (got.size() - b != 1) begin miscompares++; $display("FAIL basic_frames: got %0d want 1", got.size() - b); end
      vectors++; if (got[b] !== e) begin miscompares++; $display("FAIL basic_rec: got %h want %h", got[b], e); end
      vectors++; if (dt_n - bdt != 8) begin miscompares++; $display("FAIL basic_ticks: got %0d want 8", dt_n - bdt); end
      vectors++; if (dv_n - bdv != 1) begin miscompares++; $display("FAIL basic_dv_cycles: got %0d want 1", dv_n - bdv); end
      vectors++; if (fd_n - bfd != 1) begin miscompares++; $display("FAIL basic_fd_cycles: got %0d want 1", fd_n - bfd); end
   endtask
   task automatic test_parity();
      int b = got.size();
      rec_t e1 = model(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
      rec_t e2 = model(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
      RX_IN = 1'b1;
      wait_cyc(20);
      vectors++; if (got[b] !== e1) begin miscompares++; $display("FAIL parity_bad_rec: got %h want %h", got[b], e1); end
      vectors++; if (bus.PAR_ERR !== 1'b1) begin miscompares++; $display("FAIL parity_hold: got %b want 1", bus.PAR_ERR); end
      PRESCALE = 6'd16;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      RX_IN = 1'b0;
      wait_cyc(3);
      vectors++; if (bus.PAR_ERR !== 1'b0) begin miscompares++; $display("FAIL parity_clear_start: got %b want 0", bus.PAR_ERR); end
      wait_cyc(13);
      send_rest(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      RX_IN = 1'b1;
      wait_cyc(20);
      vectors++; if (got.size() - b != 2) begin miscompares++; $display("FAIL parity_frames: got %0d want 2", got.size() - b); end
      vectors++; if (got[b + 1] !== e2) begin miscompares++; $display("FAIL parity_good_rec: got %h want %h", got[b + 1], e2); end
   endtask
   task automatic test_glitch();
      int b = got.size(), bgl = gl_n, ben = en_n, btk = tk_n;
      PRESCALE = 6'd16;
      RX_IN = 1'b0;
      wait_cyc(3);
      RX_IN = 1'b1;
      wait_cyc(40);
      vectors++; if (gl_n - bgl != 1) begin miscompares++; $display("FAIL glitch_pulse: got %0d want 1", gl_n - bgl); end
      vectors++; if (en_n - ben != 0) begin miscompares++; $display("FAIL glitch_deser_en: got %0d want 0", en_n - ben); end
      vectors++; if (tk_n - btk != 1) begin miscompares++; $display("FAIL glitch_ticks: got %0d want 1", tk_n - btk); end
      vectors++; if (got.size() != b) begin miscompares++; $display("FAIL glitch_frames: got %0d want %0d", got.size(), b); end
   endtask
   task automatic test_break();
      int b = got.size(), bdv = dv_n;
      rec_t e = model(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      wait_cyc(200);
      vectors++; if (got.size() - b < 3) begin miscompares++; $display("FAIL break_frames: got %0d want >=3", got.size() - b); end
      vectors++; if (got[b] !== e) begin miscompares++; $display("FAIL break_first: got %h want %h", got[b], e); end
      for (int i = b + 1; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== model(8'h00, 1'b0, 1'b0, 1'b0, 1'b0))
            begin miscompares++; $display("FAIL break_repeat%0d: got %h want %h", i - b, got[i], model(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)); end
      end
      vectors++; if (dv_n != bdv) begin miscompares++; $display("FAIL break_dv: got %0d want 0", dv_n - bdv); end
      RST = 1'b0;
      RX_IN = 1'b1;
      wait_cyc(2);
      RST = 1'b1;
      wait_cyc(2);
   endtask
   task automatic test_back_to_back();
      int b = got.size(), bdv = dv_n;
      send_frame(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h34, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      RX_IN = 1'b1;
      wait_cyc(10);
      vectors++; if (dv_n - bdv != 2) begin miscompares++; $display("FAIL b2b_dv: got %0d want 2", dv_n - bdv); end
      vectors++; if (got[b] !== model(8'h12, 1'b0, 1'b0, 1'b0, 1'b1)) begin miscompares++; $display("FAIL b2b_first: got %h want %h", got[b], model(8'h12, 1'b0, 1'b0, 1'b0, 1'b1)); end
      vectors++; if (got[b + 1] !== model(8'h34, 1'b0, 1'b0, 1'b0, 1'b1)) begin miscompares++; $display("FAIL b2b_second: got %h want %h", got[b + 1], model(8'h34, 1'b0, 1'b0, 1'b0, 1'b1)); end
   endtask
   task automatic test_reset_mid();
      int bfd = fd_n, bdv = dv_n;
      logic [7:0] d = 8'hC3;
      PRESCALE = 6'd16;
      PAR_EN = 1'b0;
      drive_bit(1'b0, 16, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 16, 1'b0);
      RX_IN = d[4];
      wait_cyc(8);
      RST = 1'b0;
      wait_cyc(1);
      vectors++; if (outs() !== 9'h0) begin miscompares++; $display("FAIL rstmid_outs: got %b want %b", outs(), 9'h0); end
      RX_IN = 1'b1;
      wait_cyc(1);
      RST = 1'b1;
      wait_cyc(120);
      vectors++; if (fd_n != bfd || dv_n != bdv) begin miscompares++; $display("FAIL rstmid_no_frame: got fd %0d dv %0d want 0 0", fd_n - bfd, dv_n - bdv); end
   endtask
`ifdef UART_RX_MAJORITY_SAMPLE_EN
   task automatic test_majority();
      int b = got.size();
      send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      RX_IN = 1'b1;
      wait_cyc(12);
      vectors++; if (got[b] !== model(8'h96, 1'b0, 1'b0, 1'b0, 1'b1)) begin miscompares++; $display("FAIL majority_rec: got %h want %h", got[b], model(8'h96, 1'b0, 1'b0, 1'b0, 1'b1)); end
   endtask
`endif
   task automatic test_random();
      int b = got.size(), bdv = dv_n, ndv = 0;
      int plist[6] = '{8, 16, 32, 12, 24, 5};
      rec_t exp_q[$];
      for (int n = 0; n < 10; n++) begin
         logic [7:0] d = 8'($urandom);
         int praw = plist[$urandom_range(0, 5)];
         bit pen = 1'($urandom), ptyp = 1'($urandom), pbit = 1'($urandom);
         bit stop = $urandom_range(0, 3) != 0;
         exp_q.push_back(model(d, pen, ptyp, pbit, stop));
         if (exp_q[n].dv) ndv++;
         send_frame(d, praw, pen, ptyp, pbit, stop, -1);
         RX_IN = 1'b1;
         wait_cyc(2 * norm_p(praw) + 6);
      end
      vectors++; if (got.size() - b != exp_q.size()) begin miscompares++; $display("FAIL rand_frames: got %0d want %0d", got.size() - b, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (got[b + i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_rec%0d: got %h want %h", i, got[b + i], exp_q[i]); end
      end
      vectors++; if (dv_n - bdv != ndv) begin miscompares++; $display("FAIL rand_dv: got %0d want %0d", dv_n - bdv, ndv); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_MAJORITY_SAMPLE_EN
      test_majority();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
